// File: rtl/timbre_pkg.sv
// Shared state encoding and divider sizing helpers for the alarm-bell driver.
package timbre_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SONANDO   = 2'd1,
    ESPERA    = 2'd2,
    POSPUESTO = 2'd3
  } state_t;

  // Bits needed for a counter running 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int tono_half(input longint clk_hz, input longint tono_hz);
    return int'(clk_hz / (2 * tono_hz));
  endfunction

  // 64-bit product: PATRON_MS * CLK_HZ overflows 32 bits at real clock rates.
  function automatic int patron_cyc(input longint clk_hz, input longint patron_ms);
    return int'((patron_ms * clk_hz) / 1000);
  endfunction

endpackage

// File: rtl/gen_ticks_timbre.sv
// Three free-running dividers (tone, cadence, seconds) that restart together on clr
// and each emit a one-cycle enable on their last count.
module gen_ticks_timbre
  import timbre_pkg::*;
#(
  parameter int TONO_HALF  = 25_000,
  parameter int PATRON_CYC = 50_000_000,
  parameter int SEG_CYC    = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick_tono,
  output logic tick_patron,
  output logic tick_seg
);

  function automatic int term_of(input int idx);
    case (idx)
      0:       return TONO_HALF;
      1:       return PATRON_CYC;
      default: return SEG_CYC;
    endcase
  endfunction

  logic [2:0] ticks;

  for (genvar gi = 0; gi < 3; gi++) begin : g_div
    localparam int N = term_of(gi);
    localparam int W = cnt_w(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (reset || clr) begin
        cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign ticks[gi] = (cnt_reg == LAST);
  end

  assign tick_tono   = ticks[0];
  assign tick_patron = ticks[1];
  assign tick_seg    = ticks[2];

endmodule

// File: rtl/driver_timbre.sv
// Alarm-bell driver: rings a cadence-gated tone on a rising ring indicator.
// Optional snooze (posponer port, POSPUESTO state) with DRIVER_TIMBRE_SNOOZE_EN.
module driver_timbre
  import timbre_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TONO_HZ    = 2000,
  parameter int PATRON_MS  = 500,
  parameter int MAX_SEG    = 60,
  parameter int SNOOZE_SEG = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic alarma_on,
  input  logic activring,
  input  logic apagar,
`ifdef DRIVER_TIMBRE_SNOOZE_EN
  input  logic posponer,
`endif
  output logic timbre,
  output logic sonando,
  output logic fin_ring
);

  localparam int TONO_HALF  = tono_half(longint'(CLK_HZ), longint'(TONO_HZ));
  localparam int PATRON_CYC = patron_cyc(longint'(CLK_HZ), longint'(PATRON_MS));
  // One seconds counter serves both the ring and the snooze timers.
  localparam int SEC_W = cnt_w(max2(MAX_SEG, SNOOZE_SEG));

  state_t           state_reg, state_next;
  logic             tone_reg, tone_next;
  logic             gate_reg, gate_next;
  logic [SEC_W-1:0] sec_reg, sec_next;
  logic             act_prev_reg;
  logic             timbre_reg, sonando_reg, fin_ring_reg;
  logic             fin_next;
  logic             clr;
  logic             tick_tono, tick_patron, tick_seg;
  logic             act_rise, ring_done;

  assign act_rise  = activring & ~act_prev_reg;
  assign ring_done = tick_seg && (sec_reg == SEC_W'(MAX_SEG - 1));
`ifdef DRIVER_TIMBRE_SNOOZE_EN
  logic snooze_done;
  assign snooze_done = tick_seg && (sec_reg == SEC_W'(SNOOZE_SEG - 1));
`endif

  // Any state change restarts the dividers so every ring/snooze starts phase-aligned.
  assign clr = (state_next != state_reg);

  gen_ticks_timbre #(
    .TONO_HALF  (TONO_HALF),
    .PATRON_CYC (PATRON_CYC),
    .SEG_CYC    (CLK_HZ)
  ) u_ticks (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .tick_tono   (tick_tono),
    .tick_patron (tick_patron),
    .tick_seg    (tick_seg)
  );

  always_comb begin
    state_next = state_reg;
    tone_next  = tone_reg;
    gate_next  = gate_reg;
    sec_next   = sec_reg;
    fin_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (act_rise && alarma_on) begin
          state_next = SONANDO;
          tone_next  = 1'b0;
          gate_next  = 1'b1;
          sec_next   = '0;
        end
      end
      SONANDO: begin
        if (tick_tono)   tone_next = ~tone_reg;
        if (tick_patron) gate_next = ~gate_reg;
        if (tick_seg)    sec_next  = sec_reg + 1'b1;
        if (!alarma_on) begin
          state_next = IDLE;
        end else if (apagar || ring_done) begin
          state_next = ESPERA;
          fin_next   = 1'b1;
`ifdef DRIVER_TIMBRE_SNOOZE_EN
        end else if (posponer) begin
          state_next = POSPUESTO;
          sec_next   = '0;
`endif
        end
      end
      ESPERA: begin
        if (!alarma_on || !activring) state_next = IDLE;
      end
`ifdef DRIVER_TIMBRE_SNOOZE_EN
      POSPUESTO: begin
        if (tick_seg) sec_next = sec_reg + 1'b1;
        if (!alarma_on) begin
          state_next = IDLE;
        end else if (apagar) begin
          state_next = ESPERA;
          fin_next   = 1'b1;
        end else if (snooze_done) begin
          state_next = SONANDO;
          tone_next  = 1'b0;
          gate_next  = 1'b1;
          sec_next   = '0;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      tone_reg     <= 1'b0;
      gate_reg     <= 1'b0;
      sec_reg      <= '0;
      act_prev_reg <= 1'b1;
      timbre_reg   <= 1'b0;
      sonando_reg  <= 1'b0;
      fin_ring_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tone_reg     <= tone_next;
      gate_reg     <= gate_next;
      sec_reg      <= sec_next;
      act_prev_reg <= activring;
      timbre_reg   <= (state_next == SONANDO) & tone_next & gate_next;
      sonando_reg  <= (state_next == SONANDO);
      fin_ring_reg <= fin_next;
    end
  end

  assign timbre   = timbre_reg;
  assign sonando  = sonando_reg;
  assign fin_ring = fin_ring_reg;

endmodule
